// File: rtl/dec_key_schedule.sv
`timescale 1ns/1ps
// Iterative AES-128 decryption key schedule: expands the cipher key forward to
// round 10, then walks back one round per accepted key. The S-box is external.
module dec_key_schedule #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_key_in,
  input  logic             i_next_key,
  output logic [KEY_W-1:0] o_key_out,
  output logic [3:0]       o_round_out,
  output logic             o_key_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_sbox_in,
  input  logic [31:0]      i_sbox_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [7:0] RCON_LAST  = 8'h36;

  state_t           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key,   w_key_nxt;
  logic [3:0]       r_round, w_round_nxt;
  logic [7:0]       r_rcon,  w_rcon_nxt;
  logic             r_done,  w_done_nxt;

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_t;
  logic [31:0] w_f0, w_f1, w_f2, w_f3;
  logic [31:0] w_u0, w_u1, w_u2, w_u3;
  logic [31:0] w_sbox_in;

  function automatic logic [31:0] rot_word(input logic [31:0] a);
    return {a[23:0], a[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse of xtime: (b ^ 9'h11B) >> 1 reduces to (b >> 1) ^ 8'h8D for odd b.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return {1'b0, b[7:1]} ^ (b[0] ? 8'h8D : 8'h00);
  endfunction

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // Both directions share the single S-box port; only the word fed to it differs.
  assign w_t  = i_sbox_out ^ {r_rcon, 24'h0};

  assign w_f0 = w_w0 ^ w_t;
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;

  assign w_u3 = w_w3 ^ w_w2;
  assign w_u2 = w_w2 ^ w_w1;
  assign w_u1 = w_w1 ^ w_w0;
  assign w_u0 = w_w0 ^ w_t;

  always_comb begin
    w_sbox_in = 32'h0;
    unique case (r_state)
      FWD:     w_sbox_in = rot_word(w_w3);
      OUT:     w_sbox_in = rot_word(w_u3);
      default: w_sbox_in = 32'h0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    w_rcon_nxt  = r_rcon;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = FWD;
          w_key_nxt   = i_key_in;
          w_round_nxt = 4'd0;
          w_rcon_nxt  = 8'h01;
        end
      end
      FWD: begin
        w_key_nxt   = {w_f0, w_f1, w_f2, w_f3};
        w_round_nxt = r_round + 4'd1;
        // Park rcon at the round-10 value so the backward walk starts from it.
        if (r_round == LAST_ROUND - 4'd1) begin
          w_state_nxt = OUT;
          w_rcon_nxt  = RCON_LAST;
        end else begin
          w_rcon_nxt  = xtime(r_rcon);
        end
      end
      OUT: begin
        if (i_next_key) begin
          if (r_round != 4'd0) begin
            w_key_nxt   = {w_u0, w_u1, w_u2, w_u3};
            w_round_nxt = r_round - 4'd1;
            w_rcon_nxt  = inv_xtime(r_rcon);
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_rcon  <= 8'h01;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
      r_rcon  <= w_rcon_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_key_out   = r_key;
  assign o_round_out = r_round;
  assign o_key_valid = (r_state == OUT);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_sbox_in   = w_sbox_in;

endmodule

// File: tb/tb_dec_key_schedule.sv
`timescale 1ns/1ps
// Bench for dec_key_schedule: FIPS-197 directed vectors and random keys, scored
// through an expected-key queue filled from a forward key-expansion model.
module tb_dec_key_schedule;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] keyIn;
  logic         nextKey;
  logic [127:0] keyOut;
  logic [3:0]   roundOut;
  logic         keyValid;
  logic         busy;
  logic         done;
  logic [31:0]  sboxIn;
  logic [31:0]  sboxOut;

  logic [7:0]   sboxTable [0:255];
  logic [127:0] modelKeys [0:10];

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } expT;

  expT expQ[$];
  int  errorCount = 0;
  int  checkCount = 0;

  always #5 clk = ~clk;

  dec_key_schedule dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_key_in    (keyIn),
    .i_next_key  (nextKey),
    .o_key_out   (keyOut),
    .o_round_out (roundOut),
    .o_key_valid (keyValid),
    .o_busy      (busy),
    .o_done      (done),
    .o_sbox_in   (sboxIn),
    .i_sbox_out  (sboxOut)
  );

  // The shared datapath S-box bank, modelled as a combinational lookup
  assign sboxOut = {sboxTable[sboxIn[31:24]], sboxTable[sboxIn[23:16]],
                    sboxTable[sboxIn[15:8]],  sboxTable[sboxIn[7:0]]};

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [127:0] k, input logic n, input logic r);
    start   = s;
    keyIn   = k;
    nextKey = n;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] a);
    return {sboxTable[a[31:24]], sboxTable[a[23:16]], sboxTable[a[15:8]], sboxTable[a[7:0]]};
  endfunction

  // Textbook forward expansion into 44 words, then sliced into round keys
  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1B) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pushSchedule(input logic [127:0] key);
    expT e;
    computeModel(key);
    for (int r = 10; r >= 0; r--) begin
      e.round = 4'(r);
      e.key   = modelKeys[r];
      expQ.push_back(e);
    end
  endtask

  // Peek at the queue head every valid cycle; pop only on an accepted key
  always @(negedge clk) begin
    if (rst === 1'b0 && keyValid === 1'b1) begin
      if (expQ.size() == 0) begin
        errorCount++;
        checkCount++;
        $display("[TB] FAIL unexpectedKey: got round %0d key %h, required no valid key", roundOut, keyOut);
      end else begin
        checkOutput("schedRound", 128'(roundOut), 128'(expQ[0].round));
        checkOutput("schedKey", keyOut, expQ[0].key);
        if (nextKey === 1'b1) void'(expQ.pop_front());
      end
    end
  end

  task automatic checkReset(input string name);
    checkOutput({name, "KeyOut"}, keyOut, 128'h0);
    checkOutput({name, "RoundOut"}, 128'(roundOut), 128'h0);
    checkBit({name, "KeyValid"}, keyValid, 1'b0);
    checkBit({name, "Busy"}, busy, 1'b0);
    checkBit({name, "Done"}, done, 1'b0);
  endtask

  task automatic waitValid(input int fwdStartCycle, input logic [127:0] altKey);
    int c = 0;
    while (keyValid !== 1'b1 && c < 20) begin
      c++;
      applyStimulus(c == fwdStartCycle, altKey, 1'b0, 1'b0);
    end
    checkOutput("validLatency", 128'(c), 128'(10));
  endtask

  task automatic drainKeys(input int gapPct, input int outStartRound, input logic [127:0] altKey);
    int   g = 0;
    logic n;
    logic s;
    while (keyValid === 1'b1 && g < 400) begin
      g++;
      n = (int'($urandom_range(99, 0)) >= gapPct);
      s = (int'(roundOut) == outStartRound);
      applyStimulus(s, altKey, n, 1'b0);
    end
    checkBit("drainFinished", keyValid, 1'b0);
    checkBit("donePulse", done, 1'b1);
    checkBit("busyAfterDone", busy, 1'b0);
    checkOutput("queueDrained", 128'(expQ.size()), 128'h0);
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
    checkBit("doneSingleCycle", done, 1'b0);
  endtask

  task automatic runKey(input logic [127:0] key, input int gapPct, input int fwdStartCycle,
                        input int outStartRound, input logic [127:0] altKey);
    pushSchedule(key);
    applyStimulus(1'b1, key, 1'b0, 1'b0);
    waitValid(fwdStartCycle, altKey);
    drainKeys(gapPct, outStartRound, altKey);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    for (int i = 0; i < 256; i++) sboxTable[i] = SBOX_BITS[2047-8*i -: 8];

    $display("[TB] reset state");
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b1);
    checkReset("reset");
    checkOutput("resetSboxIn", 128'(sboxIn), 128'h0);

    $display("[TB] FIPS key, hold at round 10");
    pushSchedule(FIPS_KEY);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b0);
    checkBit("busyInFwd", busy, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
      checkBit("validRiseAt10", keyValid, (i == 10));
    end
    checkOutput("fipsR10", keyOut, FIPS_R10);
    checkOutput("fipsR10Round", 128'(roundOut), 128'(10));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
      checkOutput("holdKey", keyOut, FIPS_R10);
    end
    drainKeys(0, 15, 128'h0);

    $display("[TB] FIPS key, back-to-back stream");
    pushSchedule(FIPS_KEY);
    applyStimulus(1'b1, FIPS_KEY, 1'b1, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
      if (c == 10) checkOutput("streamR10", keyOut, FIPS_R10);
      if (c == 11) checkOutput("streamR9", keyOut, FIPS_R9);
      if (c == 19) checkOutput("streamR1", keyOut, FIPS_R1);
      if (c == 20) begin
        checkOutput("streamR0", keyOut, FIPS_KEY);
        checkOutput("streamR0Round", 128'(roundOut), 128'h0);
      end
      if (c == 21) begin
        checkBit("streamEndValid", keyValid, 1'b0);
        checkBit("streamEndDone", done, 1'b1);
        checkBit("streamEndBusy", busy, 1'b0);
        checkOutput("streamRetainR0", keyOut, FIPS_KEY);
      end
      if (c == 22) checkBit("streamDoneOnce", done, 1'b0);
    end
    checkOutput("streamQueueDrained", 128'(expQ.size()), 128'h0);

    $display("[TB] start pulses during FWD and OUT are ignored");
    runKey(FIPS_KEY, 0, 3, 5, ALT_KEY);
    runKey(FIPS_KEY, 50, 7, 5, ALT_KEY);

    $display("[TB] reset during FWD");
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b1);
    checkReset("rstFwd");
    expQ.delete();
    pushSchedule(128'h0);
    applyStimulus(1'b1, 128'h0, 1'b0, 1'b0);
    waitValid(0, 128'h0);
    checkOutput("zeroKeyR10AfterFwdRst", keyOut, ZERO_R10);
    drainKeys(30, 15, 128'h0);

    $display("[TB] reset during OUT at round 6");
    pushSchedule(FIPS_KEY);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b0);
    waitValid(0, 128'h0);
    g = 0;
    while (roundOut !== 4'd6 && g < 20) begin
      g++;
      applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
    end
    checkOutput("reachRound6", 128'(roundOut), 128'(6));
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b1);
    checkReset("rstOut");
    expQ.delete();
    pushSchedule(128'h0);
    applyStimulus(1'b1, 128'h0, 1'b0, 1'b0);
    waitValid(0, 128'h0);
    checkOutput("zeroKeyR10AfterOutRst", keyOut, ZERO_R10);
    drainKeys(0, 15, 128'h0);

    $display("[TB] start and reset together");
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b1);
    checkBit("startRstValid", keyValid, 1'b0);
    checkBit("startRstBusy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 128'h0, 1'b0, 1'b0);
      checkBit("startRstStaysIdle", busy, 1'b0);
      checkBit("startRstNoValid", keyValid, 1'b0);
    end

    $display("[TB] random keys with random next_key gaps");
    for (int k = 0; k < 200; k++) begin
      runKey({$urandom(), $urandom(), $urandom(), $urandom()},
             int'($urandom_range(60, 0)), 0, 15, 128'h0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dec_key_schedule.md
Name: dec_key_schedule

Overview:
Iterative AES-128 decryption key schedule.
- It takes the cipher key and expands it forward to round key 10.
- It then walks the schedule backwards, one round per handshake, delivering round keys 10, 9, …, 0 in the order the inverse cipher consumes them.
- It sits in front of the decryption round datapath and is the reverse-direction counterpart of the encryption key expander.
- The S-box is not instantiated here. It is accessed through a 32-bit lookup port so the datapath's existing S-box bank can be shared.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)
KEY_W, 128, key and round-key width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin schedule for key_in; honoured only in IDLE
key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
next_key  input  1  consumer accepts current key_out
key_out  output  128  current round key
round_out  output  4  round index of key_out (10 down to 0)
key_valid  output  1  key_out/round_out are valid
busy  output  1  high in FWD and OUT states
done  output  1  one-cycle pulse after round 0 key is accepted
sbox_in  output  32  word to substitute (RotWord already applied)
sbox_out  input  32  bytewise S-box of sbox_in, combinational, same cycle

Behaviour:
- Reset (synchronous, any state): state=IDLE, key_out=0, round_out=0, key_valid=0, busy=0, done=0, rcon=8'h01.
- Internal register key_reg is driven directly onto key_out. Internal registers: 4-bit round counter, 8-bit rcon.
- State IDLE:
  - Outputs key_valid=0 and busy=0.
  - On start: key_reg<=key_in, round<=0, rcon<=8'h01, go to FWD.
- State FWD (forward step, one per cycle):
  - sbox_in = RotWord(w3), where RotWord(a,b,c,d) = (b,c,d,a).
  - t = sbox_out ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - round<=round+1; rcon<=xtime(rcon), i.e. left shift, XOR 8'h1B if the MSB was set.
  - On the edge where round becomes 10: go to OUT and set rcon<=8'h36, the rcon of round 10. Do not advance it further.
  - key_valid=0 throughout FWD; start is ignored.
  - Latency: key_valid rises 10 cycles after the edge that sampled start.
- State OUT: key_valid=1, round_out=round.
  - next_key && round>0: one inverse step in a single cycle.
    - u3=w3^w2, u2=w2^w1, u1=w1^w0.
    - sbox_in=RotWord(u3).
    - u0=w0^sbox_out^{rcon,24'h0}.
    - key_reg<={u0,u1,u2,u3}; round<=round-1.
    - rcon<=inv_xtime(rcon), i.e. rcon[0] ? ((rcon^9'h11B)>>1) : rcon>>1.
    - key_valid stays 1, giving back-to-back throughput of one key per cycle.
  - next_key && round==0: go to IDLE; key_valid<=0; done<=1 for one cycle; key_reg retains the round-0 key.
  - next_key low: hold all outputs stable indefinitely.
  - start is ignored.
- sbox_in is driven in FWD and OUT per the formulas above. In IDLE it is 0.
- next_key outside OUT is ignored.
- Reset mid-FWD or mid-OUT: abort, with outputs as reset values on the next cycle. No partial key is retained.
- start and rst in the same cycle: reset wins.
- Key invariant: the sequence of key_out values in OUT equals the FIPS-197 expansion reversed, rounds 10..0. The round-0 key equals key_in.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, next_key=0:
  - key_valid rises exactly 10 cycles after start.
  - key_out = d014f9a8c9ee2589e13f0cc8b6630ca6, round_out=10.
  - Outputs hold for 20 idle cycles.
- Same key, next_key held high:
  - Keys stream one per cycle.
  - round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Acceptance at round 0 gives key_valid=0 and a single-cycle done, and busy falls.
- Random next_key gaps plus 200 random keys versus a reference model:
  - All 11 keys match in reverse order.
  - Outputs remain stable while next_key=0.
- start pulsed during FWD and during OUT (round 5) with a different key_in:
  - Ignored; the sequence continues unchanged.
- rst asserted in FWD (cycle 4) and in OUT (round 6):
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent start with the all-zero key yields round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start and rst asserted together:
  - Remains in IDLE; key_valid stays 0.
